// File: rtl/a5_or_c3_pkg.sv
// Shared constants and types for the a5_or_c3 header/payload link.
// The receiving end imports the same header codes.
package a5_or_c3_pkg;

    localparam logic [7:0] HDR_A5  = 8'hA5;
    localparam logic [7:0] HDR_C3  = 8'hC3;
    localparam int         PKT_LEN = 4;

    typedef enum logic [2:0] {
        LOAD,
        HDR,
        GAP,
        DATA,
        END
    } tx_state_t;

    // Header code selected by the latched hdr_sel bit
    function automatic logic [7:0] hdr_code(input logic sel);
        return sel ? HDR_C3 : HDR_A5;
    endfunction

    // Keep payload from aliasing a header code at the receiver
    function automatic logic [7:0] sanitize(input logic [7:0] b);
        if (b == HDR_A5 || b == HDR_C3) begin
            return b - 8'd1;
        end
        return b;
    endfunction

endpackage

// File: rtl/a5_or_c3_tx_buf.sv
// 4x8 payload buffer: one write port (slot/data) and one read port (idx).
// Define A5C3_TX_SANITIZE_EN to remap 0xA5/0xC3 payload bytes at write time.
import a5_or_c3_pkg::*;

module a5_or_c3_tx_buf (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [1:0] wr_slot,
    input  logic [7:0] wr_data,
    input  logic [1:0] rd_idx,
    output logic [7:0] rd_data
);

    logic [PKT_LEN-1:0][7:0] mem;
    logic [7:0]              wr_val;

    // Value actually stored for the incoming byte
    always_comb begin
`ifdef A5C3_TX_SANITIZE_EN
        wr_val = sanitize(wr_data);
`else
        wr_val = wr_data;
`endif
    end

    // Buffer slots, cleared on reset
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            mem <= '0;
        end else if (wr_en) begin
            mem[wr_slot] <= wr_val;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/a5_or_c3_tx.sv
// Packet framer: gathers four payload bytes, then emits header + payload
// strobes on header/header_en with GAP_CYCLES idle cycles after each strobe.
// Optional macro: A5C3_TX_SANITIZE_EN (payload 0xA5/0xC3 sent as value-1).
//
// The idle cycles after the last payload byte end with the pkt_done cycle,
// so END occupies the final gap slot (or coincides with the last payload
// strobe when GAP_CYCLES=0). The gap counter holds "cycles left minus one".
import a5_or_c3_pkg::*;

module a5_or_c3_tx #(
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       hdr_sel,
    output logic [7:0] header,
    output logic       header_en,
    output logic       busy,
    output logic       pkt_done
);

    localparam logic [1:0] LAST   = 2'(PKT_LEN - 1);
    localparam logic [2:0] GAP_M1 = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;
    localparam logic [2:0] GAP_M2 = (GAP_CYCLES > 1) ? 3'(GAP_CYCLES - 2) : 3'd0;

    tx_state_t  state;
    logic [1:0] cnt;
    logic [1:0] idx;
    logic [2:0] gcnt;
    logic       hdr_q;
    logic       tail;
    logic       wr_en;
    logic       to_data;
    logic [7:0] rd_data;

    assign wr_en = (state == LOAD) && din_valid && din_ready;

    a5_or_c3_tx_buf u_buf (
        .clk_50  (clk_50),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_slot (cnt),
        .wr_data (din),
        .rd_idx  (idx),
        .rd_data (rd_data)
    );

    // Next edge launches a payload strobe
    always_comb begin
        to_data = 1'b0;
        case (state)
            HDR:     to_data = (GAP_CYCLES == 0);
            DATA:    to_data = (GAP_CYCLES == 0) && !tail;
            GAP:     to_data = (gcnt == 3'd0) && !tail;
            default: to_data = 1'b0;
        endcase
    end

    // Framing FSM with registered outputs
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= LOAD;
            cnt       <= 2'd0;
            idx       <= 2'd0;
            gcnt      <= 3'd0;
            hdr_q     <= 1'b0;
            tail      <= 1'b0;
            din_ready <= 1'b1;
            header    <= 8'h00;
            header_en <= 1'b0;
            busy      <= 1'b0;
            pkt_done  <= 1'b0;
        end else begin
            header_en <= 1'b0;
            pkt_done  <= 1'b0;
            if (to_data) begin
                state     <= DATA;
                header    <= rd_data;
                header_en <= 1'b1;
                idx       <= idx + 2'd1;
                if (idx == LAST) begin
                    tail <= 1'b1;
                    if (GAP_CYCLES == 0) pkt_done <= 1'b1;
                end
            end else begin
                case (state)
                    LOAD: begin
                        if (wr_en) begin
                            cnt <= cnt + 2'd1;
                            if (cnt == 2'd0) hdr_q <= hdr_sel;
                            if (cnt == LAST) begin
                                state     <= HDR;
                                header    <= hdr_code(hdr_q);
                                header_en <= 1'b1;
                                din_ready <= 1'b0;
                                busy      <= 1'b1;
                                idx       <= 2'd0;
                                tail      <= 1'b0;
                            end
                        end
                    end
                    HDR: begin
                        state <= GAP;
                        gcnt  <= GAP_M1;
                    end
                    DATA: begin
                        if (!tail) begin
                            state <= GAP;
                            gcnt  <= GAP_M1;
                        end else if (GAP_CYCLES == 0) begin
                            state     <= LOAD;
                            din_ready <= 1'b1;
                            busy      <= 1'b0;
                            tail      <= 1'b0;
                        end else if (GAP_CYCLES == 1) begin
                            state    <= END;
                            pkt_done <= 1'b1;
                        end else begin
                            state <= GAP;
                            gcnt  <= GAP_M2;
                        end
                    end
                    GAP: begin
                        if (gcnt != 3'd0) begin
                            gcnt <= gcnt - 3'd1;
                        end else begin
                            state    <= END;
                            pkt_done <= 1'b1;
                        end
                    end
                    END: begin
                        state     <= LOAD;
                        din_ready <= 1'b1;
                        busy      <= 1'b0;
                        tail      <= 1'b0;
                    end
                    default: state <= LOAD;
                endcase
            end
        end
    end

endmodule
